// File: rtl/spike_packet_tx.sv
// spike_packet_tx
//   Transmit end of the spike-routing interface on the neuromorphic TCAM
//   memory. It captures one timestep's neuron fire vector and sends one
//   PacketID for every set bit, lowest neuron first, over a valid/ready
//   handshake to the TCAM Mem block.
//
// Ports
//   clk, rst_n     : single rising-edge clock, synchronous active-low reset
//   Fire_Vec       : fire bitmap for one timestep (bit i = neuron i fired)
//   Fire_Valid     : Fire_Vec is valid this cycle
//   Fire_Ready     : a new Fire_Vec can be accepted (IDLE only)
//   PacketID_Out   : spike packet ID, registered, lowest pending neuron
//   Packet_Valid   : PacketID_Out is valid
//   Packet_Ready   : Mem accepts the packet this cycle
//   MODE_Out       : MODE_F while Packet_Valid, else MODE_I
//   Step_Done      : one-cycle pulse once every packet of the timestep is sent
//   Drop_Cnt       : saturating count of fire vectors offered while busy
//
// Optional feature (macro SPIKE_TX_STATS_EN)
//   Stats_Clr      : synchronous clear of Sent_Cnt and Drop_Cnt (wins over
//                    a coincident increment)
//   Sent_Cnt       : saturating count of packet handshakes
//
// Neurons must equal 2**ID_Width so every neuron index fits a PacketID.

module spike_packet_tx #(
  parameter int         ID_Width = 4,
  parameter int         Neurons  = 16,
  parameter logic [2:0] MODE_I   = 3'b000,
  parameter logic [2:0] MODE_F   = 3'b011,
  parameter int         DropW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [Neurons-1:0]  Fire_Vec,
  input  logic                Fire_Valid,
  output logic                Fire_Ready,
  output logic [ID_Width-1:0] PacketID_Out,
  output logic                Packet_Valid,
  input  logic                Packet_Ready,
  output logic [2:0]          MODE_Out,
  output logic                Step_Done,
  output logic [DropW-1:0]    Drop_Cnt
`ifdef SPIKE_TX_STATS_EN
  ,
  input  logic                Stats_Clr,
  output logic [15:0]         Sent_Cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [Neurons-1:0] pending;
  logic [Neurons-1:0] pend_rest;
  logic               hs;
  logic               accept;
  logic               drop;
  logic               clr;

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [ID_Width-1:0] lsb_idx(input logic [Neurons-1:0] v);
    logic [ID_Width-1:0] r;
    r = '0;
    for (int i = Neurons - 1; i >= 0; i--)
      if (v[i]) r = ID_Width'(i);
    return r;
  endfunction

  // Outputs decode straight from registered state, so they are glitch-free
  // and stay stable through a stall.
  assign Fire_Ready   = (state == S_IDLE);
  assign Packet_Valid = (state == S_SEND);
  assign Step_Done    = (state == S_DONE);
  assign MODE_Out     = Packet_Valid ? MODE_F : MODE_I;

  assign hs     = Packet_Valid & Packet_Ready;
  assign accept = Fire_Valid & Fire_Ready;
  assign drop   = Fire_Valid & ~Fire_Ready;

  // The presented ID is always the lowest set bit of pending, so clearing the
  // lowest set bit removes exactly the packet just handed off.
  assign pend_rest = pending & (pending - Neurons'(1));

`ifdef SPIKE_TX_STATS_EN
  assign clr = Stats_Clr;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pending      <= '0;
      PacketID_Out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (|Fire_Vec) begin
              pending      <= Fire_Vec;
              PacketID_Out <= lsb_idx(Fire_Vec);
              state        <= S_SEND;
            end else begin
              // empty timestep: nothing to send, just signal completion
              state <= S_DONE;
            end
          end
        end
        S_SEND: begin
          if (hs) begin
            pending <= pend_rest;
            if (|pend_rest) PacketID_Out <= lsb_idx(pend_rest);
            else            state        <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  Drop_Cnt <= '0;
    else if (clr)                Drop_Cnt <= '0;
    else if (drop && ~&Drop_Cnt) Drop_Cnt <= Drop_Cnt + DropW'(1);
  end

`ifdef SPIKE_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                Sent_Cnt <= '0;
    else if (Stats_Clr)        Sent_Cnt <= '0;
    else if (hs && ~&Sent_Cnt) Sent_Cnt <= Sent_Cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spike_packet_tx.sv
// Directed bench for spike_packet_tx. Inputs change and outputs are sampled
// 1 time unit after each rising edge; expected values are hand-computed.
module tb_spike_packet_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] Fire_Vec;
  logic        Fire_Valid;
  logic        Fire_Ready;
  logic [3:0]  PacketID_Out;
  logic        Packet_Valid;
  logic        Packet_Ready;
  logic [2:0]  MODE_Out;
  logic        Step_Done;
  logic [7:0]  Drop_Cnt;
`ifdef SPIKE_TX_STATS_EN
  logic        Stats_Clr;
  logic [15:0] Sent_Cnt;
`endif

  int errors = 0;
  int checks = 0;

  spike_packet_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Fire_Vec    (Fire_Vec),
    .Fire_Valid  (Fire_Valid),
    .Fire_Ready  (Fire_Ready),
    .PacketID_Out(PacketID_Out),
    .Packet_Valid(Packet_Valid),
    .Packet_Ready(Packet_Ready),
    .MODE_Out    (MODE_Out),
    .Step_Done   (Step_Done),
    .Drop_Cnt    (Drop_Cnt)
`ifdef SPIKE_TX_STATS_EN
    ,
    .Stats_Clr   (Stats_Clr),
    .Sent_Cnt    (Sent_Cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_pkt(input string tag, input logic [3:0] id);
    chk({tag, "_valid"}, Packet_Valid, 1'b1);
    chk({tag, "_id"},    PacketID_Out, id);
    chk({tag, "_mode"},  MODE_Out,     3'b011);
  endtask

  initial begin
    rst_n        = 1'b0;
    Fire_Vec     = 16'h0000;
    Fire_Valid   = 1'b0;
    Packet_Ready = 1'b1;
`ifdef SPIKE_TX_STATS_EN
    Stats_Clr    = 1'b0;
`endif

    // reset held for two cycles
    tick(); tick();
    chk("rst_fire_ready", Fire_Ready,   1'b1);
    chk("rst_pkt_valid",  Packet_Valid, 1'b0);
    chk("rst_pkt_id",     PacketID_Out, 4'd0);
    chk("rst_mode",       MODE_Out,     3'b000);
    chk("rst_step_done",  Step_Done,    1'b0);
    chk("rst_drop_cnt",   Drop_Cnt,     8'd0);
`ifdef SPIKE_TX_STATS_EN
    chk("rst_sent_cnt",   Sent_Cnt,     16'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 16'h8421 streams IDs 0,5,10,15 back to back
    Fire_Vec = 16'h8421; Fire_Valid = 1'b1;
    tick();
    Fire_Valid = 1'b0;
    chk("v8421_busy", Fire_Ready, 1'b0);
    chk_pkt("v8421_p0", 4'd0);  tick();
    chk_pkt("v8421_p1", 4'd5);  tick();
    chk_pkt("v8421_p2", 4'd10); tick();
    chk_pkt("v8421_p3", 4'd15); tick();
    chk("v8421_done",       Step_Done,    1'b1);
    chk("v8421_done_valid", Packet_Valid, 1'b0);
    chk("v8421_done_mode",  MODE_Out,     3'b000);
    chk("v8421_done_ready", Fire_Ready,   1'b0);
    tick();
    chk("v8421_pulse_end",  Step_Done,    1'b0);
    chk("v8421_ready_back", Fire_Ready,   1'b1);

    // 16'h0006 with a 3-cycle stall on the first packet
    Fire_Vec = 16'h0006; Fire_Valid = 1'b1; Packet_Ready = 1'b0;
    tick();
    Fire_Valid = 1'b0;
    chk_pkt("stall_c0", 4'd1); tick();
    chk_pkt("stall_c1", 4'd1); tick();
    chk_pkt("stall_c2", 4'd1);
    Packet_Ready = 1'b1;
    tick();
    chk_pkt("stall_p1", 4'd2);
    chk("stall_p1_done", Step_Done, 1'b0);
    tick();
    chk("stall_done",       Step_Done,    1'b1);
    chk("stall_done_valid", Packet_Valid, 1'b0);
    tick();

    // empty vector: straight to DONE, no packet
    Fire_Vec = 16'h0000; Fire_Valid = 1'b1;
    tick();
    Fire_Valid = 1'b0;
    chk("zero_done",  Step_Done,    1'b1);
    chk("zero_valid", Packet_Valid, 1'b0);
    tick();
    chk("zero_pulse_end", Step_Done,  1'b0);
    chk("zero_ready",     Fire_Ready, 1'b1);
    chk("zero_no_valid",  Packet_Valid, 1'b0);

    // two vectors offered while sending are dropped
    Fire_Vec = 16'h0003; Fire_Valid = 1'b1; Packet_Ready = 1'b0;
    tick();
    Fire_Vec = 16'h00F0;
    tick(); tick();
    Fire_Valid = 1'b0;
    chk("drop2_cnt", Drop_Cnt, 8'd2);
    chk_pkt("drop2_pkt", 4'd0);
    Packet_Ready = 1'b1;
    tick();
    chk_pkt("drop2_p1", 4'd1);
    tick();
    chk("drop2_done", Step_Done, 1'b1);
    tick();
    chk("drop2_hold", Drop_Cnt, 8'd2);

    // 300 more drops: 2+100 = 0x66, then saturate at 0xFF
    Fire_Vec = 16'h0001; Fire_Valid = 1'b1; Packet_Ready = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) tick();
    chk("drop_102", Drop_Cnt, 8'h66);
    for (int i = 0; i < 200; i++) tick();
    chk("drop_sat", Drop_Cnt, 8'hFF);
    Fire_Valid = 1'b0; Packet_Ready = 1'b1;
    tick();
    chk("sat_done", Step_Done, 1'b1);
    tick();
    chk("sat_hold", Drop_Cnt, 8'hFF);

`ifdef SPIKE_TX_STATS_EN
    // Sent_Cnt so far: 4 + 2 + 2 + 1 = 9; clear both counters
    chk("stats_sent", Sent_Cnt, 16'd9);
    Stats_Clr = 1'b1;
    tick();
    Stats_Clr = 1'b0;
    chk("stats_clr_sent", Sent_Cnt, 16'd0);
    chk("stats_clr_drop", Drop_Cnt, 8'd0);
`endif

    // reset in the middle of sending 16'hFFFF, after 3 packets
    Fire_Vec = 16'hFFFF; Fire_Valid = 1'b1; Packet_Ready = 1'b1;
    tick();
    Fire_Valid = 1'b0;
    chk_pkt("ffff_p0", 4'd0);
    tick(); tick(); tick();
    chk_pkt("ffff_p3", 4'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", Packet_Valid, 1'b0);
    chk("mid_rst_done",  Step_Done,    1'b0);
    chk("mid_rst_id",    PacketID_Out, 4'd0);
    chk("mid_rst_drop",  Drop_Cnt,     8'd0);
`ifdef SPIKE_TX_STATS_EN
    chk("mid_rst_sent",  Sent_Cnt,     16'd0);
`endif
    tick();
    chk("post_rst_done",  Step_Done,  1'b0);
    chk("post_rst_ready", Fire_Ready, 1'b1);
    Fire_Vec = 16'h0010; Fire_Valid = 1'b1;
    tick();
    Fire_Valid = 1'b0;
    chk_pkt("post_rst_p0", 4'd4);
    tick();
    chk("post_rst_step", Step_Done, 1'b1);
    tick();
    chk("post_rst_idle", Fire_Ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
